// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-function and state definitions for the hardwired control unit.
// The data path and ALU decode the same opcode and alu_op values.
package control_unit_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_ADD4 = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T1W, ST_T2, ST_T3, ST_T4, ST_T5, ST_HALT
  } state_t;

  typedef struct packed {
    logic       is_rr;
    logic       is_imm;
    logic       is_nop;
    logic       is_halt;
    logic [3:0] alu_op;
  } decode_t;

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier: instruction class flags plus ALU function.
// An opcode that sets none of the class flags is undefined.
module cu_decode
  import control_unit_pkg::*;
(
  input  logic [4:0] op,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_ADD:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_ADD;  end
      OP_SUB:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_SUB;  end
      OP_AND:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_AND;  end
      OP_OR:   begin dec.is_rr  = 1'b1; dec.alu_op = ALU_OR;   end
      OP_SHR:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_SHR;  end
      OP_SHRA: begin dec.is_rr  = 1'b1; dec.alu_op = ALU_SHRA; end
      OP_SHL:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_SHL;  end
      OP_ROR:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_ROR;  end
      OP_ROL:  begin dec.is_rr  = 1'b1; dec.alu_op = ALU_ROL;  end
      OP_ADDI: begin dec.is_imm = 1'b1; dec.alu_op = ALU_ADD;  end
      OP_ANDI: begin dec.is_imm = 1'b1; dec.alu_op = ALU_AND;  end
      OP_ORI:  begin dec.is_imm = 1'b1; dec.alu_op = ALU_OR;   end
      OP_NOP:  dec.is_nop  = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for data_path: fetch T0-T2 (with T1W memory wait),
// execute T3-T5, plus run/halt state and a retired-instruction counter.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             Cout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             IncPC,
  output logic             Read,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [3:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t  state;
  decode_t dec;
  logic    unused_ir_bits;

  assign unused_ir_bits = ^ir[31-OP_W:0];

  cu_decode u_decode (
    .op  (ir[31 -: OP_W]),
    .dec (dec)
  );

  // ir is only consulted in T3-T5, after IRin has loaded it in T2.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= ST_IDLE;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (run) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   state <= mem_ready ? ST_T2 : ST_T1W;
        ST_T1W:  if (mem_ready) state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3: begin
          if (dec.is_rr || dec.is_imm) begin
            state <= ST_T4;
          end else if (dec.is_nop) begin
            retired <= retired + CNT_W'(1);
            state   <= run ? ST_T0 : ST_IDLE;
          end else begin
            state <= ST_HALT;
            if (!dec.is_halt) illegal <= 1'b1;
          end
        end
        ST_T4:   state <= ST_T5;
        ST_T5: begin
          retired <= retired + CNT_W'(1);
          state   <= run ? ST_T0 : ST_IDLE;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign halted = (state == ST_HALT);

  // Strobes decode straight from state: IR is loaded on the same edge that enters T3.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    alu_op = ALU_ADD;
    case (state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        alu_op = ALU_ADD4;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T1W: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        if (dec.is_rr || dec.is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      ST_T4: begin
        if (dec.is_rr) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = dec.alu_op;
        end else if (dec.is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = dec.alu_op;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe patterns, wait states,
// halt/illegal handling, clear mid-instruction and bus-driver exclusivity.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic        PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin;
  logic        Yin, Zin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [3:0]  alu_op;
  logic        halted, illegal;
  logic [15:0] retired;

  int compareCount = 0;
  int failCount    = 0;
  int pcinCount    = 0;
  bit monitorOn    = 1'b0;

  // Strobe vector order: PCout Zlowout MDRout Cout MARin PCin MDRin IRin Yin Zin IncPC Read Gra Grb Grc Rin Rout
  localparam logic [16:0] S_PCOUT   = 17'h1 << 16;
  localparam logic [16:0] S_ZLOWOUT = 17'h1 << 15;
  localparam logic [16:0] S_MDROUT  = 17'h1 << 14;
  localparam logic [16:0] S_COUT    = 17'h1 << 13;
  localparam logic [16:0] S_MARIN   = 17'h1 << 12;
  localparam logic [16:0] S_PCIN    = 17'h1 << 11;
  localparam logic [16:0] S_MDRIN   = 17'h1 << 10;
  localparam logic [16:0] S_IRIN    = 17'h1 << 9;
  localparam logic [16:0] S_YIN     = 17'h1 << 8;
  localparam logic [16:0] S_ZIN     = 17'h1 << 7;
  localparam logic [16:0] S_INCPC   = 17'h1 << 6;
  localparam logic [16:0] S_READ    = 17'h1 << 5;
  localparam logic [16:0] S_GRA     = 17'h1 << 4;
  localparam logic [16:0] S_GRB     = 17'h1 << 3;
  localparam logic [16:0] S_GRC     = 17'h1 << 2;
  localparam logic [16:0] S_RIN     = 17'h1 << 1;
  localparam logic [16:0] S_ROUT    = 17'h1;

  localparam logic [16:0] EXP_NONE  = 17'h0;
  localparam logic [16:0] EXP_T0    = S_PCOUT | S_MARIN | S_ZIN | S_INCPC;
  localparam logic [16:0] EXP_T1    = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [16:0] EXP_T1W   = S_READ | S_MDRIN;
  localparam logic [16:0] EXP_T2    = S_MDROUT | S_IRIN;
  localparam logic [16:0] EXP_T3    = S_GRB | S_ROUT | S_YIN;
  localparam logic [16:0] EXP_T4RR  = S_GRC | S_ROUT | S_ZIN;
  localparam logic [16:0] EXP_T4IMM = S_COUT | S_ZIN;
  localparam logic [16:0] EXP_T5    = S_ZLOWOUT | S_GRA | S_RIN;

  localparam logic [31:0] IR_AND  = 32'h2891_8000;
  localparam logic [31:0] IR_ADDI = 32'h6000_0000;
  localparam logic [31:0] IR_SUB  = 32'h2000_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;

  logic [16:0] strobes;
  logic [4:0]  busDrivers;
  assign strobes    = {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin,
                       Yin, Zin, IncPC, Read, Gra, Grb, Grc, Rin, Rout};
  assign busDrivers = {PCout, Zlowout, MDRout, Cout, Rout};

  control_unit #(.CNT_W(16), .OP_W(5)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic runVal, input logic [31:0] irVal, input logic memReadyVal);
    run       = runVal;
    ir        = irVal;
    mem_ready = memReadyVal;
  endtask

  task automatic stepCheck(input string tag, input logic [16:0] expStrobes, input logic [3:0] expAlu);
    @(posedge clock); #1;
    checkOutput({tag, ".strobes"}, 32'(strobes), 32'(expStrobes));
    checkOutput({tag, ".alu_op"}, 32'(alu_op), 32'(expAlu));
    if (PCin) pcinCount++;
  endtask

  task automatic fetchPhase(input string tag);
    stepCheck({tag, ".T0"}, EXP_T0, 4'd9);
    stepCheck({tag, ".T1"}, EXP_T1, 4'd0);
    stepCheck({tag, ".T2"}, EXP_T2, 4'd0);
  endtask

  // At most one driver on the shared bus in every cycle.
  always @(negedge clock) begin
    if (monitorOn)
      checkOutput("bus_onehot", 32'($countones(busDrivers) <= 1), 32'd1);
  end

  initial begin
    clear = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("reset.strobes", 32'(strobes), 32'd0);
    checkOutput("reset.alu_op", 32'(alu_op), 32'd0);
    checkOutput("reset.halted", 32'(halted), 32'd0);
    checkOutput("reset.illegal", 32'(illegal), 32'd0);
    checkOutput("reset.retired", 32'(retired), 32'd0);
    clear = 1'b0;
    monitorOn = 1'b1;
    stepCheck("idle_hold", EXP_NONE, 4'd0);

    // and R1,R2,R3 with no wait states
    applyStimulus(1'b1, IR_AND, 1'b1);
    fetchPhase("and");
    stepCheck("and.T3", EXP_T3, 4'd0);
    stepCheck("and.T4", EXP_T4RR, 4'd2);
    stepCheck("and.T5", EXP_T5, 4'd0);
    checkOutput("and.retired_T5", 32'(retired), 32'd0);
    run = 1'b0;
    stepCheck("and.idle", EXP_NONE, 4'd0);
    checkOutput("and.retired", 32'(retired), 32'd1);

    // Same instruction with mem_ready low for three cycles starting in T1
    pcinCount = 0;
    applyStimulus(1'b1, IR_AND, 1'b0);
    stepCheck("wait.T0", EXP_T0, 4'd9);
    stepCheck("wait.T1", EXP_T1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      stepCheck($sformatf("wait.T1W%0d", i), EXP_T1W, 4'd0);
      if (i == 2) mem_ready = 1'b1;
    end
    stepCheck("wait.T2", EXP_T2, 4'd0);
    stepCheck("wait.T3", EXP_T3, 4'd0);
    stepCheck("wait.T4", EXP_T4RR, 4'd2);
    stepCheck("wait.T5", EXP_T5, 4'd0);
    run = 1'b0;
    stepCheck("wait.idle", EXP_NONE, 4'd0);
    checkOutput("wait.pcin_once", 32'(pcinCount), 32'd1);
    checkOutput("wait.retired", 32'(retired), 32'd2);

    // addi then sub back to back; run dropped during the sub's T2
    applyStimulus(1'b1, IR_ADDI, 1'b1);
    fetchPhase("addi");
    stepCheck("addi.T3", EXP_T3, 4'd0);
    stepCheck("addi.T4", EXP_T4IMM, 4'd0);
    stepCheck("addi.T5", EXP_T5, 4'd0);
    ir = IR_SUB;
    stepCheck("sub.T0", EXP_T0, 4'd9);
    checkOutput("addi.retired", 32'(retired), 32'd3);
    stepCheck("sub.T1", EXP_T1, 4'd0);
    stepCheck("sub.T2", EXP_T2, 4'd0);
    run = 1'b0;
    stepCheck("sub.T3", EXP_T3, 4'd0);
    stepCheck("sub.T4", EXP_T4RR, 4'd1);
    stepCheck("sub.T5", EXP_T5, 4'd0);
    stepCheck("sub.idle", EXP_NONE, 4'd0);
    checkOutput("sub.retired", 32'(retired), 32'd4);
    stepCheck("sub.idle_hold", EXP_NONE, 4'd0);

    // nop retires at T3
    applyStimulus(1'b1, IR_NOP, 1'b1);
    fetchPhase("nop");
    stepCheck("nop.T3", EXP_NONE, 4'd0);
    run = 1'b0;
    stepCheck("nop.idle", EXP_NONE, 4'd0);
    checkOutput("nop.retired", 32'(retired), 32'd5);

    // clear during T4 wins over the sequence
    applyStimulus(1'b1, IR_AND, 1'b1);
    fetchPhase("clr");
    stepCheck("clr.T3", EXP_T3, 4'd0);
    stepCheck("clr.T4", EXP_T4RR, 4'd2);
    clear = 1'b1;
    stepCheck("clr.idle", EXP_NONE, 4'd0);
    checkOutput("clr.retired", 32'(retired), 32'd0);
    clear = 1'b0;
    run   = 1'b0;
    stepCheck("clr.idle_hold", EXP_NONE, 4'd0);

    // halt opcode: HALT without illegal, run toggling ignored
    applyStimulus(1'b1, IR_HALT, 1'b1);
    fetchPhase("halt");
    stepCheck("halt.T3", EXP_NONE, 4'd0);
    checkOutput("halt.T3_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      stepCheck($sformatf("halt.hold%0d", i), EXP_NONE, 4'd0);
      checkOutput("halt.halted", 32'(halted), 32'd1);
      checkOutput("halt.illegal", 32'(illegal), 32'd0);
      run = i[0];
    end
    checkOutput("halt.retired", 32'(retired), 32'd0);
    clear = 1'b1;
    stepCheck("halt.clear", EXP_NONE, 4'd0);
    checkOutput("halt.cleared", 32'(halted), 32'd0);
    clear = 1'b0;

    // undefined opcode: HALT with sticky illegal, cleared only by clear
    applyStimulus(1'b1, IR_BAD, 1'b1);
    fetchPhase("bad");
    stepCheck("bad.T3", EXP_NONE, 4'd0);
    for (int i = 0; i < 3; i++) begin
      stepCheck($sformatf("bad.hold%0d", i), EXP_NONE, 4'd0);
      checkOutput("bad.halted", 32'(halted), 32'd1);
      checkOutput("bad.illegal", 32'(illegal), 32'd1);
      run = ~run;
    end
    clear = 1'b1;
    stepCheck("bad.clear", EXP_NONE, 4'd0);
    checkOutput("bad.illegal_cleared", 32'(illegal), 32'd0);
    checkOutput("bad.halted_cleared", 32'(halted), 32'd0);
    clear = 1'b0;
    run   = 1'b0;
    stepCheck("bad.idle_hold", EXP_NONE, 4'd0);

    monitorOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
